// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit (8 ops) with zero/all-ones flags; optional accumulator via LOGIC_PIPE_ACC_EN.
// Latency 2 cycles from input transfer to out_valid, throughput 1/cycle.
// Backpressure: valid/ready on both sides; a full pipe stalls in_ready while out_ready=0.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             zero,
    output logic             ones
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("logic_unit_pipe: WIDTH must be >= 2");
        end
    endgenerate

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_zero;
    logic             r_ones;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [WIDTH-1:0] w_op7;
    logic [WIDTH-1:0] w_res;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

`ifdef LOGIC_PIPE_ACC_EN
    logic [WIDTH-1:0] r_acc;

    // acc is written on the edge the ACC_OR result enters s2, so a following ACC_OR sees it
    assign w_op7 = r_acc | r_s1_a;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_s2_load && r_s1_valid && (r_s1_op == 3'b111)) begin
            r_acc <= w_res;
        end
    end
`else
    logic w_unused_acc_clr;

    assign w_unused_acc_clr = acc_clr;
    assign w_op7            = r_s1_a;
`endif

    always_comb begin
        w_res = '0;
        unique case (r_s1_op)
            3'b000:  w_res = r_s1_a & r_s1_b;
            3'b001:  w_res = r_s1_a | r_s1_b;
            3'b010:  w_res = r_s1_a ^ r_s1_b;
            3'b011:  w_res = ~(r_s1_a | r_s1_b);
            3'b100:  w_res = ~(r_s1_a & r_s1_b);
            3'b101:  w_res = ~(r_s1_a ^ r_s1_b);
            3'b110:  w_res = r_s1_a & ~r_s1_b;
            default: w_res = w_op7;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_load) begin
                r_s1_op <= op;
                r_s1_a  <= A;
                r_s1_b  <= B;
            end
        end
    end

    // Result and flags only change when s2 is free or draining, keeping S stable under stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s        <= '0;
            r_zero     <= 1'b0;
            r_ones     <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s    <= w_res;
                r_zero <= (w_res == '0);
                r_ones <= &w_res;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign S         = r_s;
    assign zero      = r_zero;
    assign ones      = r_ones;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe (WIDTH=32): directed scenarios plus randomized handshake run against a truth-table model.
module tb_logic_unit_pipe;
    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         zero;
    logic         ones;

    int checks;
    int failures;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .zero(zero), .ones(ones)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Truth table per op, indexed by {a_bit, b_bit}
    logic [3:0] tt [8];
    initial begin
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0001;
        tt[4] = 4'b0111; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1100;
    end

    function automatic logic [W-1:0] ref_logic(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [3:0]   t;
        t = tt[o];
        for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    // Drive inputs on the falling edge; outputs are sampled 1 ns later, well before the rising edge
    task automatic drive(input logic iv, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy, input logic clr);
        @(negedge clock);
        in_valid = iv; op = o; A = a; B = b; out_ready = ordy; acc_clr = clr;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (S !== '0) begin failures++; $display("FAIL reset_S got=%h want=0", S); end
        checks++; if (zero !== 1'b0 || ones !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", zero, ones); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        reset = 1'b1;
    endtask

    task automatic test_single_or;
        drive(1'b1, 3'd2, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
        drive(1'b1, 3'd0, 32'hFFFF_0000, 32'h00FF_FF00, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        reset = 1'b1;
        drive(1'b1, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL or_in_ready got=%b want=1", in_ready); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL or_early_valid got=%b want=0", out_valid); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || S !== 32'hF0F0_0F0F) begin
            failures++; $display("FAIL or_result got=%b/%h want=1/f0f00f0f", out_valid, S); end
        checks++; if (zero !== 1'b0 || ones !== 1'b0) begin failures++; $display("FAIL or_flags got=%b%b want=00", zero, ones); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ea [8];
        logic [W-1:0] eb [8];
        logic [W-1:0] ex;
        for (int k = 0; k < 8; k++) begin
            ea[k] = $urandom; eb[k] = $urandom;
        end
        ea[2] = 32'hDEAD_BEEF; eb[2] = 32'hDEAD_BEEF;
        ea[3] = '0;            eb[3] = '0;
        // acc_clr on the first cycle makes op 111 behave as S=A in both builds
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, 3'(c), ea[c], eb[c], 1'b1, c == 0);
            else       drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
            if (c >= 2) begin
                ex = ref_logic(3'(c - 2), ea[c-2], eb[c-2]);
                checks++; if (out_valid !== 1'b1 || S !== ex || zero !== (ex == '0) || ones !== (ex == '1)) begin
                    failures++;
                    $display("FAIL b2b_op%0d got=%b/%h/%b%b want=1/%h/%b%b", c - 2, out_valid, S, zero, ones,
                             ex, ex == '0, ex == '1);
                end
            end
        end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_stall;
        logic [W-1:0] ra, rb;
        ra = ref_logic(3'd1, 32'hA5A5_0001, 32'h0000_1000);
        rb = ref_logic(3'd6, 32'hFFFF_FFFF, 32'h0000_FFFF);
        drive(1'b1, 3'd1, 32'hA5A5_0001, 32'h0000_1000, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 3'd2, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || S !== ra) begin
                failures++; $display("FAIL stall_hold c=%0d got=%b/%h want=1/%h", c, out_valid, S, ra); end
        end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || S !== ra) begin failures++; $display("FAIL drain_first got=%b/%h want=1/%h", out_valid, S, ra); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || S !== rb) begin failures++; $display("FAIL drain_second got=%b/%h want=1/%h", out_valid, S, rb); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_extra got=%b want=0", out_valid); end
    endtask

    task automatic test_random;
        logic [W-1:0] q [$];
        logic [W-1:0] ex, prev_s;
        logic         iv, ordy, prev_hold, in_x, out_x;
        logic [2:0]   o;
        int           sent, got, cyc;
        sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev_s = '0;
        while (got < 10000 && cyc < 60000) begin
            iv   = (sent < 10000) && ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 1) == 1);
`ifdef LOGIC_PIPE_ACC_EN
            o = 3'($urandom_range(0, 6));
`else
            o = 3'($urandom_range(0, 7));
`endif
            drive(iv, o, $urandom, $urandom, ordy, 1'b0);
            if (prev_hold) begin
                checks++; if (out_valid !== 1'b1 || S !== prev_s) begin
                    failures++; $display("FAIL rnd_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, S, prev_s); end
            end
            in_x  = iv && in_ready;
            out_x = out_valid && ordy;
            if (out_x) begin
                if (q.size() == 0) begin
                    checks++; failures++; $display("FAIL rnd_spurious cyc=%0d got=%h want=none", cyc, S);
                end else begin
                    ex = q.pop_front();
                    checks++; if (S !== ex || zero !== (ex == '0) || ones !== (ex == '1)) begin
                        failures++; $display("FAIL rnd_result n=%0d got=%h/%b%b want=%h/%b%b", got, S, zero, ones,
                                             ex, ex == '0, ex == '1);
                    end
                end
                got++;
            end
            if (in_x) begin
                q.push_back(ref_logic(o, A, B));
                sent++;
            end
            prev_hold = out_valid && !ordy;
            prev_s    = S;
            cyc++;
        end
        checks++; if (got != 10000 || q.size() != 0) begin
            failures++; $display("FAIL rnd_count got=%0d/%0d want=10000/0", got, q.size()); end
    endtask

    task automatic test_reset_full;
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1357_9BDF, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0);
        drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_before_reset got=%b/%b want=1/0", out_valid, in_ready); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || S !== '0 || zero !== 1'b0 || ones !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%b/%h/%b%b want=0/0/00", out_valid, S, zero, ones); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_in_ready got=%b want=1", in_ready); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        reset = 1'b1;
        drive(1'b1, 3'd5, 32'hCAFE_0000, 32'h35FF_1234, 1'b1, 1'b0);
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || S !== ref_logic(3'd5, 32'hCAFE_0000, 32'h35FF_1234)) begin
            failures++; $display("FAIL post_reset_first got=%b/%h want=1/%h", out_valid, S,
                                 ref_logic(3'd5, 32'hCAFE_0000, 32'h35FF_1234)); end
        drive(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_extra got=%b want=0", out_valid); end
    endtask

    task automatic test_op111;
        logic [W-1:0] av [8];
        logic [W-1:0] ex [8];
        logic         vv [8];
        logic         cl [8];
        av = '{0, 32'h1, 32'h4, 32'h100, 32'h2, 32'h8, 0, 0};
        vv = '{0, 1, 1, 1, 1, 1, 0, 0};
        cl = '{1, 0, 0, 0, 0, 1, 0, 0};
`ifdef LOGIC_PIPE_ACC_EN
        ex = '{0, 0, 0, 32'h1, 32'h5, 32'h105, 32'h107, 32'h8};
`else
        ex = '{0, 0, 0, 32'h1, 32'h4, 32'h100, 32'h2, 32'h8};
`endif
        for (int c = 0; c < 8; c++) begin
            drive(vv[c], 3'd7, av[c], $urandom, 1'b1, cl[c]);
            if (c >= 3) begin
                checks++; if (out_valid !== 1'b1 || S !== ex[c] || zero !== 1'b0 || ones !== 1'b0) begin
                    failures++; $display("FAIL op111 c=%0d got=%b/%h/%b%b want=1/%h/00", c, out_valid, S, zero, ones, ex[c]); end
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; in_valid = 1'b0; op = '0; A = '0; B = '0; acc_clr = 1'b0; out_ready = 1'b0;
        test_reset;
        test_single_or;
        test_back_to_back;
        test_stall;
        test_random;
        test_reset_full;
        test_op111;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
